ssp_tx_fifo: RTL and testbench

- Transmit FIFO for the SSP, sitting between the processor write interface and the serial transmit logic.
- Pushes processor writes on the phi1 strobe and pops toward the shifter on the phi2 strobe. Both strobes come from the clock management unit.
- Drives the interrupt pair that the clock management unit consumes. A full FIFO raises int_o[1], which puts the phase generator into its hold state.
- Everything runs on the single system clock; phi1/phi2 are used only as one-cycle enables, never as clocks.

---
 rtl/ssp_tx_fifo.sv | 84 ++++++++
 tb/tb_ssp_tx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: processor writes pushed on phi1, shifter pops on phi2.
// Occupancy drives the full/empty interrupt pair for the clock management unit.
module ssp_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              phi1,
  input  logic              phi2,
  input  logic              psel,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              tx_pop,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic [AW:0]       count,
  output logic              ovf,
  output logic [1:0]        int_o
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_ovf;

  logic w_full;
  logic w_empty;
  logic w_wr_req;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_req = phi1 & psel & pwrite;
  // Full blocks the push even when a pop frees a slot this cycle.
  assign w_push   = w_wr_req & ~w_full;
  assign w_pop    = phi2 & tx_pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (!clear && w_push) begin
      r_mem[r_wr_ptr] <= pwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // A new overflow wins over a same-cycle clear request.
      if (w_wr_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign tx_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign tx_valid = ~w_empty;
  assign count    = r_count;
  assign ovf      = r_ovf;
  assign int_o    = {w_full, w_empty};

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Directed self-checking bench for ssp_tx_fifo with hand-computed expectations.
module tb_ssp_tx_fifo;

  logic       clk;
  logic       clear;
  logic       phi1;
  logic       phi2;
  logic       psel;
  logic       pwrite;
  logic [7:0] pwdata;
  logic       tx_pop;
  logic       ovf_clr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] count;
  logic       ovf;
  logic [1:0] int_o;

  int unsigned n_checks;
  int unsigned n_fail;

  ssp_tx_fifo #(.DATA_W(8), .DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .clear    (clear),
    .phi1     (phi1),
    .phi2     (phi2),
    .psel     (psel),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .tx_pop   (tx_pop),
    .ovf_clr  (ovf_clr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .count    (count),
    .ovf      (ovf),
    .int_o    (int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    phi1 = 1'b0; psel = 1'b0; pwrite = 1'b0; phi2 = 1'b0; tx_pop = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    phi1 = 1'b1; psel = 1'b1; pwrite = 1'b1; pwdata = d;
    tick();
    idle();
  endtask

  task automatic do_pop();
    phi2 = 1'b1; tx_pop = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_both(input logic [7:0] d);
    phi1 = 1'b1; psel = 1'b1; pwrite = 1'b1; pwdata = d; phi2 = 1'b1; tx_pop = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    logic [7:0] exp_d;
    n_checks = 0;
    n_fail   = 0;
    idle();
    pwdata = 8'h00;

    // Reset with a write attempt held active
    clear = 1'b1; phi1 = 1'b1; psel = 1'b1; pwrite = 1'b1; pwdata = 8'hAA;
    tick(); tick();
    clear = 1'b0;
    idle();
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'h0);
    check("rst_int", 32'(int_o), 32'b01);
    check("rst_ovf", 32'(ovf), 32'd0);

    // Fill
    do_push(8'h11);
    check("first_push_data", 32'(tx_data), 32'h11);
    check("first_push_valid", 32'(tx_valid), 32'd1);
    do_push(8'h22); do_push(8'h33); do_push(8'h44);
    check("full_count", 32'(count), 32'd4);
    check("full_int", 32'(int_o), 32'b10);
    check("full_head", 32'(tx_data), 32'h11);
    check("full_ovf0", 32'(ovf), 32'd0);
    do_push(8'h55);
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_head", 32'(tx_data), 32'h11);

    // Drain order
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'(8'h11 * (i + 1));
      check("drain_data", 32'(tx_data), 32'(exp_d));
      do_pop();
    end
    check("drained_count", 32'(count), 32'd0);
    check("drained_data", 32'(tx_data), 32'h0);
    check("drained_int", 32'(int_o), 32'b01);
    do_pop();
    check("empty_pop_count", 32'(count), 32'd0);
    check("empty_pop_ovf", 32'(ovf), 32'd1);

    // Wrap-around
    do_push(8'h01); do_push(8'h02); do_push(8'h03);
    do_pop(); do_pop(); do_pop();
    check("wrap_empty", 32'(count), 32'd0);
    for (int i = 0; i < 4; i++) do_push(8'(8'hA0 + i));
    check("wrap_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'(8'hA0 + i);
      check("wrap_data", 32'(tx_data), 32'(exp_d));
      do_pop();
    end
    check("wrap_end_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count=2
    do_push(8'hB0); do_push(8'hB1);
    do_both(8'hB2);
    check("sim2_count", 32'(count), 32'd2);
    check("sim2_head", 32'(tx_data), 32'hB1);

    // Full with push+pop: pop only, overflow flagged
    ovf_clr = 1'b1; tick(); idle();
    check("ovf_clr_pre", 32'(ovf), 32'd0);
    do_push(8'hB3); do_push(8'hB4);
    check("sim_full_pre", 32'(count), 32'd4);
    do_both(8'hB5);
    check("simfull_count", 32'(count), 32'd3);
    check("simfull_ovf", 32'(ovf), 32'd1);
    check("simfull_head", 32'(tx_data), 32'hB2);

    // Overflow concurrent with ovf_clr keeps the flag set
    do_push(8'hB6);
    check("refull_count", 32'(count), 32'd4);
    phi1 = 1'b1; psel = 1'b1; pwrite = 1'b1; pwdata = 8'hB7; ovf_clr = 1'b1;
    tick(); idle();
    check("ovf_vs_clr", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; tick(); idle();
    check("ovf_clr_alone", 32'(ovf), 32'd0);

    // Reset mid-operation together with a push
    do_pop();
    check("mid_count3", 32'(count), 32'd3);
    check("mid_head", 32'(tx_data), 32'hB3);
    clear = 1'b1; phi1 = 1'b1; psel = 1'b1; pwrite = 1'b1; pwdata = 8'hC0;
    tick();
    clear = 1'b0; idle();
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_int", 32'(int_o), 32'b01);
    check("midrst_valid", 32'(tx_valid), 32'd0);
    do_push(8'h5A);
    check("post_rst_data", 32'(tx_data), 32'h5A);
    check("post_rst_count", 32'(count), 32'd1);

    // Push+pop while empty: pop blocked, pushed word becomes head
    do_pop();
    check("re_empty", 32'(count), 32'd0);
    do_both(8'h77);
    check("simempty_count", 32'(count), 32'd1);
    check("simempty_head", 32'(tx_data), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
